ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//   Shares one simple dual-port ram (clk, en, r_addr, w_addr, data_in, data_out) between two
//   requesters, e.g. the weight loader and the systolic-array feeder. Read and write ports are
//   arbitrated independently, round-robin, with valid/ready handshakes. Read data returns one cycle
//   after the grant. The ram has no separate write enable, so idle write slots go to a scratch word.
// PARAMETERS
//   ADDR_WIDTH    5     ram address width
//   DATA_WIDTH    8     ram data width
//   SCRATCH_ADDR  2**ADDR_WIDTH-1   reserved word, target of dummy writes; not for requester use
// PORTS
//   clk         in   1             clock, rising edge
//   rst_n       in   1             asynchronous active-low reset
//   rd_valid    in   2             per-requester read request
//   rd_ready    out  2             read grant; a transfer happens when valid&ready
//   rd_addr     in   2*ADDR_WIDTH  read addresses, requester i in bits [i*AW +: AW]
//   wr_valid    in   2             per-requester write request
//   wr_ready    out  2             write grant
//   wr_addr     in   2*ADDR_WIDTH  write addresses
//   wr_data     in   2*DATA_WIDTH  write data
//   rsp_valid   out  2             read response strobe, one cycle wide
//   rsp_data    out  DATA_WIDTH    read response data, common to both requesters
//   err         out  1             pulse: a request targeted SCRATCH_ADDR
//   ram_en      out  1             to ram en
//   ram_r_addr  out  ADDR_WIDTH    to ram r_addr
//   ram_w_addr  out  ADDR_WIDTH    to ram w_addr
//   ram_din     out  DATA_WIDTH    to ram data_in
//   ram_dout    in   DATA_WIDTH    from ram data_out
// BEHAVIOUR
//   RAM contract: when en=1 at a clk edge, mem[w_addr]<=data_in and data_out<=mem[r_addr]
//     (the old value on a same-address read/write). When en=0, the ram holds.
//   Reset: rd_ptr=wr_ptr=0, rsp_valid=0, rsp_data=0, err=0, pending response cleared.
//     Reset asserted mid-operation drops any in-flight response.
//   Arbitration, per port, combinational from the valid inputs and the registered pointer:
//     - Single requester: granted.
//     - Both requesters: the one whose index equals the port's ptr is granted.
//     - ptr <= ~granted index after each transfer; it holds when the port is idle.
//     - At most one grant per port per cycle. A read and a write in the same cycle both proceed.
//   ram_en = any rd grant | any wr grant.
//     - No write grant: ram_w_addr=SCRATCH_ADDR, ram_din=0.
//     - No read grant: ram_r_addr=SCRATCH_ADDR.
//   Read latency 1: a transfer at edge N gives rsp_valid[i]=1 for the cycle after edge N+1, with
//     rsp_data = ram_dout registered. Responses are not back-pressured; requesters always accept.
//     Back-to-back reads reach full throughput, one per cycle.
//   Scratch guard: a granted write to SCRATCH_ADDR is accepted (ready=1) and dropped. The
//     ram_w_addr stays SCRATCH_ADDR and ram_din is forced to 0. A granted read of SCRATCH_ADDR
//     returns 0. Either case pulses err for one cycle.
// CONFIGURATION
//   RAM_ARB_BYPASS_EN defined: same-cycle granted read and write to the same non-scratch address
//     return wr_data, the new value, on rsp_data.
//   Not defined: that case returns the old memory value, straight from ram_dout. Logic is absent.
// STRUCTURE
//   Shared package ram_arb_pkg: REQ_NUM=2, requester index typedef, default SCRATCH_ADDR function.
//   Sub-module rr_arb2: 2-way round-robin arbiter holding the pointer. It is instantiated twice,
//     once for the read port and once for the write port.
//   The ram is instantiated by the parent, not inside this block.
// TESTING  (ADDR_WIDTH=5, DATA_WIDTH=8, SCRATCH_ADDR=31, real ram instance)
//   1. Req0 writes addr 3=0x45, then reads 3
//      -> rsp_valid=2'b01 one cycle after the read grant; rsp_data=0x45.
//   2. Both requesters read every cycle, addrs 4/5, for 6 cycles
//      -> grants alternate 0,1,0,1...; each rsp_valid arrives 1 cycle after its grant.
//   3. Req0 reads only, 10 cycles
//      -> mem[0..30] unchanged; only mem[31] is written, with 0.
//   4. Req1 writes addr 31=0xAA
//      -> wr_ready=1, err pulses 1 cycle, mem[31]=0, no other word changes.
//   5. Addr 7 holds 0x11; same cycle req0 reads 7, req1 writes 7=0x22
//      -> rsp_data=0x22 with RAM_ARB_BYPASS_EN, 0x11 without; mem[7]=0x22 afterwards.
//   6. rst_n low the cycle after a read grant
//      -> no rsp_valid; pointers reset to 0; requester 0 wins the first contention after reset.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the two-requester ram arbiter.
package ram_arb_pkg;

    localparam int REQ_NUM = 2;

    typedef logic [$clog2(REQ_NUM)-1:0] req_idx_t;

    // The top word of the address space is reserved as the dummy-write target.
    function automatic int default_scratch_addr(input int addrWidth);
        return (1 << addrWidth) - 1;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the favoured requester under contention.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [REQ_NUM-1:0] valid_i,
    output logic [REQ_NUM-1:0] grant_o,
    output req_idx_t           gntIdx_o,
    output logic               gntAny_o
);

    req_idx_t ptr_q;
    req_idx_t ptr_d;

    always_comb begin
        grant_o  = valid_i;
        if (valid_i == 2'b11) begin
            grant_o = (ptr_q == 1'b1) ? 2'b10 : 2'b01;
        end
        gntAny_o = |valid_i;
        gntIdx_o = grant_o[1];
        // After a transfer the other requester becomes favoured; idle cycles keep the pointer.
        ptr_d    = ptr_q;
        if (gntAny_o) begin
            ptr_d = ~gntIdx_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one simple dual-port ram between two requesters with independent read/write arbitration.
// Optional RAM_ARB_BYPASS_EN: a same-cycle read and write to one address returns the new data.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 8,
    parameter int SCRATCH_ADDR = default_scratch_addr(ADDR_WIDTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REQ_NUM-1:0]        rd_valid_i,
    output logic [REQ_NUM-1:0]        rd_ready_o,
    input  logic [2*ADDR_WIDTH-1:0]   rd_addr_i,
    input  logic [REQ_NUM-1:0]        wr_valid_i,
    output logic [REQ_NUM-1:0]        wr_ready_o,
    input  logic [2*ADDR_WIDTH-1:0]   wr_addr_i,
    input  logic [2*DATA_WIDTH-1:0]   wr_data_i,
    output logic [REQ_NUM-1:0]        rsp_valid_o,
    output logic [DATA_WIDTH-1:0]     rsp_data_o,
    output logic                      err_o,
    output logic                      ram_en_o,
    output logic [ADDR_WIDTH-1:0]     ram_r_addr_o,
    output logic [ADDR_WIDTH-1:0]     ram_w_addr_o,
    output logic [DATA_WIDTH-1:0]     ram_din_o,
    input  logic [DATA_WIDTH-1:0]     ram_dout_i
);

    localparam logic [ADDR_WIDTH-1:0] SCRATCH = ADDR_WIDTH'(SCRATCH_ADDR);

    logic [REQ_NUM-1:0]    rdGrant;
    logic [REQ_NUM-1:0]    wrGrant;
    req_idx_t              rdIdx;
    req_idx_t              wrIdx;
    logic                  rdAny;
    logic                  wrAny;
    logic [ADDR_WIDTH-1:0] rdAddrSel;
    logic [ADDR_WIDTH-1:0] wrAddrSel;
    logic [DATA_WIDTH-1:0] wrDataSel;
    logic                  rdScratch;
    logic                  wrScratch;
    logic                  wrLive;
    logic [DATA_WIDTH-1:0] readData;

    logic [REQ_NUM-1:0]    pendValid_q;
    logic                  pendScratch_q;
    logic [REQ_NUM-1:0]    rspValid_q;
    logic [DATA_WIDTH-1:0] rspData_q;
    logic [DATA_WIDTH-1:0] rspData_d;
    logic                  err_q;

    rr_arb2 uRdArb (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_i  (rd_valid_i),
        .grant_o  (rdGrant),
        .gntIdx_o (rdIdx),
        .gntAny_o (rdAny)
    );

    rr_arb2 uWrArb (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_i  (wr_valid_i),
        .grant_o  (wrGrant),
        .gntIdx_o (wrIdx),
        .gntAny_o (wrAny)
    );

    // The ram has no write enable: whenever it is clocked, an idle or dropped write lands on scratch as 0.
    always_comb begin
        rdAddrSel    = rdIdx ? rd_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : rd_addr_i[ADDR_WIDTH-1:0];
        wrAddrSel    = wrIdx ? wr_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : wr_addr_i[ADDR_WIDTH-1:0];
        wrDataSel    = wrIdx ? wr_data_i[2*DATA_WIDTH-1:DATA_WIDTH] : wr_data_i[DATA_WIDTH-1:0];
        rdScratch    = rdAny && (rdAddrSel == SCRATCH);
        wrScratch    = wrAny && (wrAddrSel == SCRATCH);
        wrLive       = wrAny && !wrScratch;
        ram_en_o     = rdAny | wrAny;
        ram_r_addr_o = rdAny ? rdAddrSel : SCRATCH;
        ram_w_addr_o = wrLive ? wrAddrSel : SCRATCH;
        ram_din_o    = wrLive ? wrDataSel : '0;
    end

`ifdef RAM_ARB_BYPASS_EN
    logic                  bypassHit;
    logic                  bypass_q;
    logic [DATA_WIDTH-1:0] bypassData_q;

    assign bypassHit = rdAny && wrLive && (rdAddrSel == wrAddrSel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bypass_q     <= 1'b0;
            bypassData_q <= '0;
        end else begin
            bypass_q     <= bypassHit;
            bypassData_q <= wrDataSel;
        end
    end

    assign readData = bypass_q ? bypassData_q : ram_dout_i;
`else
    assign readData = ram_dout_i;
`endif

    always_comb begin
        rspData_d = rspData_q;
        if (|pendValid_q) begin
            rspData_d = pendScratch_q ? '0 : readData;
        end
    end

    // Grant edge captures the request; the following edge captures the ram output as the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pendValid_q   <= '0;
            pendScratch_q <= 1'b0;
            rspValid_q    <= '0;
            rspData_q     <= '0;
            err_q         <= 1'b0;
        end else begin
            pendValid_q   <= rdGrant;
            pendScratch_q <= rdScratch;
            rspValid_q    <= pendValid_q;
            rspData_q     <= rspData_d;
            err_q         <= rdScratch | wrScratch;
        end
    end

    assign rd_ready_o  = rdGrant;
    assign wr_ready_o  = wrGrant;
    assign rsp_valid_o = rspValid_q;
    assign rsp_data_o  = rspData_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural ram and a response scoreboard.
module tb_ram_arbiter;

    localparam logic [4:0] SCR = 5'd31;
`ifdef RAM_ARB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  rd_valid, rd_ready, wr_valid, wr_ready, rsp_valid;
    logic [9:0]  rd_addr, wr_addr;
    logic [15:0] wr_data;
    logic [7:0]  rsp_data;
    logic        err;
    logic        ram_en;
    logic [4:0]  ram_r_addr, ram_w_addr;
    logic [7:0]  ram_din;
    logic [7:0]  ramDout;

    logic [7:0]  mem    [32];
    logic [7:0]  expMem [32];
    logic [7:0]  snap   [32];

    typedef struct {
        int         due;
        logic [1:0] valid;
        logic [7:0] data;
    } rsp_t;

    rsp_t        sbQ[$];
    rsp_t        head;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [1:0]  expRdG, expWrG;
    logic        expErr;
    logic        expRdPtr, expWrPtr;

    ram_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_valid_i   (rd_valid),
        .rd_ready_o   (rd_ready),
        .rd_addr_i    (rd_addr),
        .wr_valid_i   (wr_valid),
        .wr_ready_o   (wr_ready),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .rsp_valid_o  (rsp_valid),
        .rsp_data_o   (rsp_data),
        .err_o        (err),
        .ram_en_o     (ram_en),
        .ram_r_addr_o (ram_r_addr),
        .ram_w_addr_o (ram_w_addr),
        .ram_din_o    (ram_din),
        .ram_dout_i   (ramDout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (ram_en) begin
            mem[ram_w_addr] <= ram_din;
            ramDout         <= mem[ram_r_addr];
        end
    end

    // Response monitor: every strobe must match the oldest expected response, on its due cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            checks++;
            if (rsp_valid !== 2'b00) begin
                errors++;
                $display("[TB] FAIL rsp_in_reset got %b want 00", rsp_valid);
            end
        end else if (rsp_valid !== 2'b00) begin
            checks++;
            if (sbQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL rsp_unexpected got valid %b data %h", rsp_valid, rsp_data);
            end else begin
                head = sbQ.pop_front();
                if (rsp_valid !== head.valid || rsp_data !== head.data || cyc != head.due) begin
                    errors++;
                    $display("[TB] FAIL rsp got valid %b data %h cyc %0d want valid %b data %h cyc %0d",
                             rsp_valid, rsp_data, cyc, head.valid, head.data, head.due);
                end
            end
        end else if (sbQ.size() > 0 && sbQ[0].due <= cyc) begin
            checks++;
            errors++;
            head = sbQ.pop_front();
            $display("[TB] FAIL rsp_missing got valid 00 want valid %b data %h at cyc %0d",
                     head.valid, head.data, head.due);
        end
    end

    function automatic logic [1:0] pickGrant(input logic [1:0] v, input logic p);
        if (v == 2'b11) return p ? 2'b10 : 2'b01;
        return v;
    endfunction

    // Drives one cycle of requests and updates the reference model and scoreboard.
    task automatic drive(input logic [1:0] rv, input logic [4:0] ra0, input logic [4:0] ra1,
                         input logic [1:0] wv, input logic [4:0] wa0, input logic [4:0] wa1,
                         input logic [7:0] wd0, input logic [7:0] wd1);
        logic [4:0] rA, wA;
        logic [7:0] wD, d;
        logic       rdAny, wrAny;
        @(negedge clk);
        rd_valid = rv;
        rd_addr  = {ra1, ra0};
        wr_valid = wv;
        wr_addr  = {wa1, wa0};
        wr_data  = {wd1, wd0};
        #1;
        expRdG = pickGrant(rv, expRdPtr);
        expWrG = pickGrant(wv, expWrPtr);
        rdAny  = |expRdG;
        wrAny  = |expWrG;
        rA     = expRdG[1] ? ra1 : ra0;
        wA     = expWrG[1] ? wa1 : wa0;
        wD     = expWrG[1] ? wd1 : wd0;
        expErr = (rdAny && rA == SCR) || (wrAny && wA == SCR);
        if (rdAny) begin
            if (rA == SCR) d = 8'h00;
            else if (BYPASS && wrAny && wA == rA) d = wD;
            else d = expMem[rA];
            sbQ.push_back('{due: cyc + 2, valid: expRdG, data: d});
        end
        if (wrAny && wA != SCR) expMem[wA] = wD;
        if (rdAny || wrAny) expMem[SCR] = 8'h00;
        if (rdAny) expRdPtr = ~expRdG[1];
        if (wrAny) expWrPtr = ~expWrG[1];
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        rd_valid = 2'b00;
        wr_valid = 2'b00;
        rd_addr  = '0;
        wr_addr  = '0;
        wr_data  = '0;
        expRdPtr = 1'b0;
        expWrPtr = 1'b0;
        #2;
        checks++;
        if (rsp_valid !== 2'b00 || rsp_data !== 8'h00 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %b/%h/%b want 00/00/0", rsp_valid, rsp_data, err);
        end
        rd_valid = 2'b11;
        wr_valid = 2'b11;
        #1;
        checks++;
        if (rd_ready !== 2'b01 || wr_ready !== 2'b01) begin
            errors++;
            $display("[TB] FAIL reset_ptr got rd %b wr %b want 01 01", rd_ready, wr_ready);
        end
        rd_valid = 2'b00;
        wr_valid = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        drive(2'b00, 5'd0, 5'd0, 2'b01, 5'd3, 5'd0, 8'h45, 8'h00);
        checks++;
        if (wr_ready !== 2'b01) begin
            errors++;
            $display("[TB] FAIL wr_grant got %b want 01", wr_ready);
        end
        drive(2'b01, 5'd3, 5'd0, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
        checks++;
        if (rd_ready !== 2'b01) begin
            errors++;
            $display("[TB] FAIL rd_grant got %b want 01", rd_ready);
        end
        idle(3);
    endtask

    task automatic test_back_to_back();
        logic [1:0] prevG;
        prevG = 2'b00;
        for (int i = 0; i < 6; i++) begin
            drive(2'b11, 5'd4, 5'd5, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
            checks++;
            if (rd_ready !== expRdG || (i > 0 && rd_ready !== ~prevG)) begin
                errors++;
                $display("[TB] FAIL rr_alternate cycle %0d got %b want %b", i, rd_ready, expRdG);
            end
            prevG = rd_ready;
        end
        idle(3);
    endtask

    task automatic test_read_only();
        int bad;
        for (int a = 0; a < 32; a++) snap[a] = mem[a];
        for (int i = 0; i < 10; i++) begin
            drive(2'b01, 5'(i), 5'd0, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
            checks++;
            if (rd_ready !== 2'b01) begin
                errors++;
                $display("[TB] FAIL rd_only_grant cycle %0d got %b want 01", i, rd_ready);
            end
        end
        idle(3);
        bad = 0;
        for (int a = 0; a < 31; a++) if (mem[a] !== snap[a]) bad++;
        checks++;
        if (bad != 0 || mem[31] !== 8'h00) begin
            errors++;
            $display("[TB] FAIL rd_only_mem got %0d changed words, mem31 %h want 0 changed, mem31 00", bad, mem[31]);
        end
    endtask

    task automatic test_scratch_guard();
        int bad;
        drive(2'b00, 5'd0, 5'd0, 2'b10, 5'd0, SCR, 8'h00, 8'hAA);
        checks++;
        if (wr_ready !== 2'b10) begin
            errors++;
            $display("[TB] FAIL scratch_wr_ready got %b want 10", wr_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (err !== expErr || err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL scratch_err got %b want 1", err);
        end
        drive(2'b01, 5'd9, 5'd0, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL scratch_err_pulse got %b want 0", err);
        end
        drive(2'b10, 5'd0, SCR, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL scratch_rd_err got %b want 1", err);
        end
        idle(3);
        bad = 0;
        for (int a = 0; a < 32; a++) if (mem[a] !== expMem[a]) bad++;
        checks++;
        if (bad != 0 || mem[31] !== 8'h00) begin
            errors++;
            $display("[TB] FAIL scratch_mem got %0d bad words, mem31 %h want 0 bad, mem31 00", bad, mem[31]);
        end
    endtask

    task automatic test_same_addr();
        drive(2'b00, 5'd0, 5'd0, 2'b01, 5'd7, 5'd0, 8'h11, 8'h00);
        drive(2'b01, 5'd7, 5'd0, 2'b10, 5'd0, 5'd7, 8'h00, 8'h22);
        checks++;
        if (rd_ready !== 2'b01 || wr_ready !== 2'b10) begin
            errors++;
            $display("[TB] FAIL same_addr_grant got rd %b wr %b want 01 10", rd_ready, wr_ready);
        end
        idle(3);
        checks++;
        if (mem[7] !== 8'h22) begin
            errors++;
            $display("[TB] FAIL same_addr_mem got %h want 22", mem[7]);
        end
    endtask

    task automatic test_reset_mid();
        drive(2'b01, 5'd4, 5'd0, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        rd_valid = 2'b00;
        wr_valid = 2'b00;
        sbQ.delete();
        expRdPtr = 1'b0;
        expWrPtr = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (rsp_data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_mid_data got %h want 00", rsp_data);
        end
        rst_n = 1'b1;
        drive(2'b11, 5'd4, 5'd5, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
        checks++;
        if (rd_ready !== 2'b01) begin
            errors++;
            $display("[TB] FAIL reset_mid_ptr got %b want 01", rd_ready);
        end
        idle(3);
    endtask

    initial begin
        for (int a = 0; a < 32; a++) begin
            mem[a]    <= 8'(a * 5 + 3);
            expMem[a]  = 8'(a * 5 + 3);
        end
        ramDout <= 8'h00;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_read_only();
        test_scratch_guard();
        test_same_addr();
        test_reset_mid();
        idle(2);
        checks++;
        if (sbQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain got %0d pending responses want 0", sbQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout got running want finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
